value_to_pwm: RTL and testbench

//  Inverse of the PWM receive path: converts an 8-bit command value into a servo/ESC-style PWM pulse train.

---
 rtl/value_to_pwm_pkg.sv | 29 ++
 rtl/value_to_pwm_if.sv | 15 +
 rtl/value_to_pwm_period_counter.sv | 29 ++
 rtl/value_to_pwm.sv | 125 ++++++++++++
 tb/tb_value_to_pwm.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/value_to_pwm_pkg.sv
// Shared widths, default timing constants, FSM encoding and the high-time helper
// for the value-to-PWM output stage.
package value_to_pwm_pkg;

  localparam int PWM_VALUE_BIT_WIDTH = 8;
  localparam int PWM_TIME_BIT_WIDTH  = 16;

  localparam int MIN_HIGH_US_DEF     = 1000;
  localparam int PERIOD_US_DEF       = 2500;
  localparam int VALUE_SHIFT_DEF     = 2;
  localparam int ARM_PERIODS_DEF     = 50;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } pwm_state_t;

  typedef logic [PWM_TIME_BIT_WIDTH-1:0]  pwm_time_t;
  typedef logic [PWM_VALUE_BIT_WIDTH-1:0] pwm_value_t;

  function automatic pwm_time_t calc_high_time(input int min_us, input int shift,
                                               input pwm_value_t value);
    pwm_time_t value_ext;
    value_ext = pwm_time_t'(value);
    return pwm_time_t'(min_us) + (value_ext << shift);
  endfunction

endpackage

// File: rtl/value_to_pwm_if.sv
// Command/status bundle between a flight-controller motor channel and its PWM stage.
interface value_to_pwm_if;
  import value_to_pwm_pkg::*;

  logic       enable;
  pwm_value_t value_in;
  logic       pwm_out;
  logic       period_start;
  logic       armed;

  modport master (output enable, output value_in,
                  input  pwm_out, input period_start, input armed);
  modport slave  (input  enable, input value_in,
                  output pwm_out, output period_start, output armed);
endinterface

// File: rtl/value_to_pwm_period_counter.sv
// Free-running period counter: counts 0..PERIOD_US-1 while run is high, flags the last cycle.
module value_to_pwm_period_counter
  import value_to_pwm_pkg::*;
#(
  parameter int PERIOD_US = PERIOD_US_DEF
) (
  input  logic      us_clk,
  input  logic      reset,
  input  logic      run,
  output pwm_time_t cnt,
  output logic      wrap
);

  localparam pwm_time_t LAST = pwm_time_t'(PERIOD_US - 1);

  pwm_time_t cnt_reg;

  assign cnt  = cnt_reg;
  assign wrap = run && (cnt_reg == LAST);

  always_ff @(posedge us_clk) begin
    if (reset || !run || wrap) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/value_to_pwm.sv
// Converts an 8-bit motor command into a servo/ESC PWM pulse train, emitting a run of
// minimum-width arming pulses after every enable before the command is honoured.
module value_to_pwm
  import value_to_pwm_pkg::*;
#(
  parameter int MIN_PWM_TIME_HIGH_US = MIN_HIGH_US_DEF,
  parameter int PERIOD_US            = PERIOD_US_DEF,
  parameter int VALUE_SHIFT          = VALUE_SHIFT_DEF,
  parameter int ARM_PERIODS          = ARM_PERIODS_DEF
) (
  input  logic          us_clk,
  input  logic          reset,
  value_to_pwm_if.slave bus
);

  localparam int ARM_W = (ARM_PERIODS < 2) ? 1 : $clog2(ARM_PERIODS + 1);

  // The longest possible pulse must still leave a low phase inside the period.
  if (MIN_PWM_TIME_HIGH_US + (255 << VALUE_SHIFT) >= PERIOD_US) begin : g_bad_timing
    $error("value_to_pwm: maximum high time does not fit in PERIOD_US");
  end

  pwm_state_t       state_reg, state_next;
  pwm_time_t        high_reg, high_next;
  logic [ARM_W-1:0] arm_cnt_reg, arm_cnt_next;
  logic             pwm_reg, pwm_next;
  logic             start_reg, start_next;
  logic             armed_reg, armed_next;

  pwm_time_t cnt;
  logic      wrap;
  pwm_time_t value_high;

  assign value_high = calc_high_time(MIN_PWM_TIME_HIGH_US, VALUE_SHIFT, bus.value_in);

  value_to_pwm_period_counter #(.PERIOD_US(PERIOD_US)) u_counter (
    .us_clk (us_clk),
    .reset  (reset),
    .run    (state_reg != ST_IDLE),
    .cnt    (cnt),
    .wrap   (wrap)
  );

  always_ff @(posedge us_clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      high_reg    <= '0;
      arm_cnt_reg <= '0;
      pwm_reg     <= 1'b0;
      start_reg   <= 1'b0;
      armed_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      high_reg    <= high_next;
      arm_cnt_reg <= arm_cnt_next;
      pwm_reg     <= pwm_next;
      start_reg   <= start_next;
      armed_reg   <= armed_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    high_next    = high_reg;
    arm_cnt_next = arm_cnt_reg;
    armed_next   = armed_reg;
    start_next   = 1'b0;
    // pwm_reg is high on cnt 0, so it stays high for exactly high_reg cycles.
    pwm_next     = (cnt + 1'b1) < high_reg;

    case (state_reg)
      ST_IDLE: begin
        pwm_next = 1'b0;
        if (bus.enable) begin
          start_next = 1'b1;
          pwm_next   = 1'b1;
          if (ARM_PERIODS == 0) begin
            state_next = ST_RUN;
            armed_next = 1'b1;
            high_next  = value_high;
          end else begin
            state_next = ST_ARM;
            high_next  = pwm_time_t'(MIN_PWM_TIME_HIGH_US);
          end
        end
      end
      ST_ARM, ST_RUN: begin
        if (wrap) begin
          if (!bus.enable) begin
            // Only ever leave at a period boundary so the last pulse is never truncated.
            state_next   = ST_IDLE;
            pwm_next     = 1'b0;
            armed_next   = 1'b0;
            arm_cnt_next = '0;
          end else begin
            start_next = 1'b1;
            pwm_next   = 1'b1;
            if (state_reg == ST_RUN) begin
              high_next = value_high;
            end else begin
              arm_cnt_next = arm_cnt_reg + 1'b1;
              if (32'(arm_cnt_reg) + 1 >= ARM_PERIODS) begin
                state_next = ST_RUN;
                armed_next = 1'b1;
                high_next  = value_high;
              end else begin
                high_next  = pwm_time_t'(MIN_PWM_TIME_HIGH_US);
              end
            end
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        pwm_next   = 1'b0;
        armed_next = 1'b0;
      end
    endcase
  end

  assign bus.pwm_out      = pwm_reg;
  assign bus.period_start = start_reg;
  assign bus.armed        = armed_reg;

endmodule

// File: tb/tb_value_to_pwm.sv
// Directed bench for value_to_pwm: period-by-period vector table plus hand-written
// disable, re-arm and mid-pulse reset sequences.
module tb_value_to_pwm;

  logic us_clk = 1'b0;
  logic reset  = 1'b1;

  value_to_pwm_if bus();

  value_to_pwm #(
    .MIN_PWM_TIME_HIGH_US (1000),
    .PERIOD_US            (2500),
    .VALUE_SHIFT          (2),
    .ARM_PERIODS          (2)
  ) dut (
    .us_clk (us_clk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 us_clk = ~us_clk;

  typedef struct {
    logic [7:0] drive;       // value_in applied at this period start (used from the next period)
    int         change_at;   // cycle within the period to change value_in, -1 for none
    logic [7:0] change_val;
    int         exp_high;
    bit         exp_armed;
  } vec_t;

  vec_t vec [12];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Entered at the negedge of a period_start cycle; leaves at the next one.
  task automatic run_vec(input int i);
    int high;
    int n;
    bit arm0;
    bus.value_in = vec[i].drive;
    arm0 = bus.armed;
    high = bus.pwm_out ? 1 : 0;
    n = 1;
    while (n <= 3000) begin
      @(negedge us_clk);
      if (bus.period_start) break;
      if (n == vec[i].change_at) bus.value_in = vec[i].change_val;
      high += bus.pwm_out ? 1 : 0;
      n++;
    end
    $display("vec %0d: high=%0d period=%0d armed=%0d", i, high, n, arm0);
    check($sformatf("vec%0d_high", i), high, vec[i].exp_high);
    check($sformatf("vec%0d_period", i), n, 2500);
    check($sformatf("vec%0d_armed", i), int'(arm0), int'(vec[i].exp_armed));
  endtask

  initial begin
    #(100000 * 10);
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int high;

    vec[0]  = '{8'd200, -1,  8'd0,   1000, 1'b0};
    vec[1]  = '{8'd200, -1,  8'd0,   1000, 1'b0};
    vec[2]  = '{8'd0,   -1,  8'd0,   1800, 1'b1};
    vec[3]  = '{8'd255, -1,  8'd0,   1000, 1'b1};
    vec[4]  = '{8'd10,  -1,  8'd0,   2020, 1'b1};
    vec[5]  = '{8'd10,  -1,  8'd0,   1040, 1'b1};
    vec[6]  = '{8'd10,  300, 8'd250, 1040, 1'b1};
    vec[7]  = '{8'd250, -1,  8'd0,   2000, 1'b1};
    vec[8]  = '{8'd200, -1,  8'd0,   1000, 1'b0};
    vec[9]  = '{8'd200, -1,  8'd0,   1000, 1'b0};
    vec[10] = '{8'd200, -1,  8'd0,   1800, 1'b1};
    vec[11] = '{8'd200, -1,  8'd0,   1000, 1'b0};

    bus.enable   = 1'b0;
    bus.value_in = 8'd0;
    reset        = 1'b1;
    repeat (3) @(negedge us_clk);
    check("reset_pwm", int'(bus.pwm_out), 0);
    check("reset_start", int'(bus.period_start), 0);
    check("reset_armed", int'(bus.armed), 0);
    reset = 1'b0;

    // Disabled: nothing may toggle.
    bad = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge us_clk);
      if (bus.pwm_out || bus.period_start || bus.armed) bad++;
    end
    $display("idle: %0d active cycles", bad);
    check("idle_quiet", bad, 0);

    bus.value_in = 8'd200;
    bus.enable   = 1'b1;
    @(negedge us_clk);
    $display("enable: pwm=%0d start=%0d", bus.pwm_out, bus.period_start);
    check("latency_pwm", int'(bus.pwm_out), 1);
    check("latency_start", int'(bus.period_start), 1);

    for (int i = 0; i < 8; i++) run_vec(i);

    // Drop enable mid-pulse: the 2000-cycle pulse and the period must still finish.
    high = bus.pwm_out ? 1 : 0;
    for (int n = 1; n < 2500; n++) begin
      @(negedge us_clk);
      if (n == 500) bus.enable = 1'b0;
      high += bus.pwm_out ? 1 : 0;
    end
    $display("disable: high=%0d armed_tail=%0d", high, bus.armed);
    check("disable_high", high, 2000);
    check("disable_armed_tail", int'(bus.armed), 1);
    @(negedge us_clk);
    check("disable_wrap_pwm", int'(bus.pwm_out), 0);
    check("disable_wrap_start", int'(bus.period_start), 0);
    check("disable_wrap_armed", int'(bus.armed), 0);
    bad = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge us_clk);
      if (bus.pwm_out || bus.period_start || bus.armed) bad++;
    end
    check("disabled_quiet", bad, 0);

    bus.value_in = 8'd200;
    bus.enable   = 1'b1;
    @(negedge us_clk);
    $display("re-enable: pwm=%0d start=%0d", bus.pwm_out, bus.period_start);
    check("reenable_start", int'(bus.period_start), 1);
    for (int i = 8; i < 11; i++) run_vec(i);

    // Reset in the middle of an 1800-cycle RUN pulse, enable held.
    repeat (400) @(negedge us_clk);
    reset = 1'b1;
    @(negedge us_clk);
    $display("mid reset: pwm=%0d armed=%0d start=%0d", bus.pwm_out, bus.armed, bus.period_start);
    check("midreset_pwm", int'(bus.pwm_out), 0);
    check("midreset_armed", int'(bus.armed), 0);
    check("midreset_start", int'(bus.period_start), 0);
    reset = 1'b0;
    @(negedge us_clk);
    check("restart_start", int'(bus.period_start), 1);
    check("restart_pwm", int'(bus.pwm_out), 1);
    run_vec(11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
